// File: rtl/add_share_arb_if.sv
// -----------------------------------------------------------------------------
// add_share_arb_if
// Bundles the requester channel, the shared-adder operand/result wires and the
// response channel of add_share_arb.
//
//   master : the arbiter side (add_share_arb). Drives grants, adder operands,
//            the response channel and busy.
//   slave  : the environment side (requesters, shared adder, result consumer).
//
// Signals:
//   req_valid [NREQ]        per-requester operation request
//   req_ready [NREQ]        one-hot grant/accept strobe
//   req_a/req_b [NREQ*W]    flattened operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/add_b [WIDTH]     registered operands to the shared adder
//   add_y [WIDTH]           sum from the shared adder (combinational)
//   rsp_valid/rsp_ready     response handshake
//   rsp_sum [WIDTH]         registered, truncated sum
//   rsp_id [IDW]            owner of rsp_sum
//   busy                    arbiter not idle
// -----------------------------------------------------------------------------
interface add_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    modport master (
        input  req_valid, req_a, req_b, add_y, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, busy
    );

    modport slave (
        output req_valid, req_a, req_b, add_y, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, busy
    );
endinterface

// File: rtl/add_share_arb.sv
// -----------------------------------------------------------------------------
// add_share_arb
// Round-robin scheduler sharing one external WIDTH-bit combinational adder
// among NREQ requesters. One operation is in flight at a time: the winning
// operands are registered onto the adder inputs, the sum is captured one cycle
// later and returned with the requester ID on a valid/ready response channel.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    add_share_arb_if.master (requests, adder operands/result, response)
//
// Parameters WIDTH/NREQ/IDW must match the connected interface instance.
// Legal NREQ is 2..8 with 2**IDW >= NREQ.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrating; req_ready is the combinational round-robin winner
// EXEC  | operands on the adder; sum captured at the end of this cycle
// RESP  | rsp_valid held until rsp_ready; no grants
// -----------------------------------------------------------------------------
module add_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    add_share_arb_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [IDW-1:0]   last_grant;
    logic [NREQ-1:0]  hi_mask;
    logic [NREQ-1:0]  hi_req;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [NREQ-1:0]  win_onehot;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    logic [NREQ-1:0]  grant;
    logic             accept;

    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_valid_q;

    // Round-robin winner: the lowest-indexed valid requester above last_grant
    // if there is one, otherwise the lowest-indexed valid requester overall.
    // This is the same as searching last_grant+1, last_grant+2, ... mod NREQ.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (IDW'(i) > last_grant);
        end
        hi_req    = bus.req_valid & hi_mask;
        win_found = |bus.req_valid;

        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_idx = IDW'(i);
            end
        end
        // Runs second so a requester above last_grant overrides the wrap pick.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                win_idx = IDW'(i);
            end
        end
    end

    // One-hot of the winner and operand select without a variable part-select.
    always_comb begin
        win_onehot = '0;
        win_a      = '0;
        win_b      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_found && (IDW'(i) == win_idx)) begin
                win_onehot[i] = 1'b1;
                win_a         = bus.req_a[i*WIDTH +: WIDTH];
                win_b         = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst_n so no grant is ever shown while reset is held.
                if (rst_n && win_found) begin
                    grant     = win_onehot;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                // Return to IDLE only; the next grant is a cycle later.
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            last_grant  <= IDW'(NREQ - 1);
        end else begin
            // add_a/add_b keep their last operands after completion.
            if (accept) begin
                add_a_q    <= win_a;
                add_b_q    <= win_b;
                rsp_id_q   <= win_idx;
                last_grant <= win_idx;
            end
            if (state == EXEC) begin
                rsp_sum_q   <= bus.add_y;
                rsp_valid_q <= 1'b1;
            end
            if ((state == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_add_share_arb.sv
module tb_add_share_arb;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    add_share_arb_if #(.WIDTH(8), .NREQ(4), .IDW(3)) bus ();

    add_share_arb #(.WIDTH(8), .NREQ(4), .IDW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared combinational adder, carry discarded.
    assign bus.add_y = bus.add_a + bus.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = 32'hFFFF_FFFF;
        bus.req_b     = 32'hFFFF_FFFF;
        bus.rsp_ready = 1'b0;
        tick();
        #1;
        n_checks++;
        if ({bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.busy} !== 36'd0)
            $display("FAIL reset_outputs: got rdy=%b a=%h b=%h v=%b s=%h id=%0d busy=%b want all zero",
                     bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.busy);
        else n_pass++;
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_a     = {24'h0, 8'h12};
        bus.req_b     = {24'h0, 8'h34};
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001)
            $display("FAIL single_ready: got %b want 0001", bus.req_ready);
        else n_pass++;
        tick();
        bus.req_valid = '0;
        #1;
        n_checks++;
        if ({bus.busy, bus.rsp_valid, bus.req_ready, bus.add_a, bus.add_b} !== {1'b1, 1'b0, 4'b0000, 8'h12, 8'h34})
            $display("FAIL single_exec: got busy=%b v=%b rdy=%b a=%h b=%h want 1 0 0000 12 34",
                     bus.busy, bus.rsp_valid, bus.req_ready, bus.add_a, bus.add_b);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.busy, bus.rsp_valid, bus.rsp_sum, bus.rsp_id} !== {1'b1, 1'b1, 8'h46, 3'd0})
            $display("FAIL single_resp: got busy=%b v=%b sum=%h id=%0d want 1 1 46 0",
                     bus.busy, bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
        else n_pass++;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.rsp_valid, bus.add_a, bus.add_b} !== {1'b0, 1'b0, 8'h12, 8'h34})
            $display("FAIL single_done: got busy=%b v=%b a=%h b=%h want 0 0 12 34",
                     bus.busy, bus.rsp_valid, bus.add_a, bus.add_b);
        else n_pass++;
    endtask

    task automatic test_rotation();
        logic [7:0] exp_sum [4];
        int id;
        exp_sum[0] = 8'h12;   // 11+01
        exp_sum[1] = 8'h55;   // 22+33
        exp_sum[2] = 8'h10;   // F0+20, carry dropped
        exp_sum[3] = 8'h00;   // 7F+81, carry dropped
        do_reset();
        bus.req_a     = {8'h7F, 8'hF0, 8'h22, 8'h11};
        bus.req_b     = {8'h81, 8'h20, 8'h33, 8'h01};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            id = g % 4;
            #1;
            n_checks++;
            if (bus.req_ready !== (4'b0001 << id))
                $display("FAIL rotate_grant%0d: got %b want %b", g, bus.req_ready, 4'b0001 << id);
            else n_pass++;
            tick();
            tick();
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id} !== {1'b1, exp_sum[id], 3'(id)})
                $display("FAIL rotate_resp%0d: got v=%b sum=%h id=%0d want 1 %h %0d",
                         g, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, exp_sum[id], id);
            else n_pass++;
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int         ids [2];
        logic [7:0] va  [2];
        logic [7:0] vb  [2];
        ids[0] = 1; va[0] = 8'hFF; vb[0] = 8'h01;
        ids[1] = 2; va[1] = 8'h80; vb[1] = 8'h80;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            bus.req_a = '0;
            bus.req_b = '0;
            bus.req_a[ids[k]*8 +: 8] = va[k];
            bus.req_b[ids[k]*8 +: 8] = vb[k];
            bus.req_valid = 4'b0001 << ids[k];
            #1;
            n_checks++;
            if (bus.req_ready !== (4'b0001 << ids[k]))
                $display("FAIL ovf_grant%0d: got %b want %b", k, bus.req_ready, 4'b0001 << ids[k]);
            else n_pass++;
            tick();
            bus.req_valid = '0;
            tick();
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id} !== {1'b1, 8'h00, 3'(ids[k])})
                $display("FAIL ovf_sum%0d: got v=%b sum=%h id=%0d want 1 00 %0d",
                         k, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, ids[k]);
            else n_pass++;
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_a     = {8'h44, 8'h33, 8'h22, 8'h05};
        bus.req_b     = {8'h01, 8'h01, 8'h01, 8'h0A};
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready, bus.busy} !== {1'b1, 8'h0F, 3'd0, 4'b0000, 1'b1})
                $display("FAIL bp_hold%0d: got v=%b sum=%h id=%0d rdy=%b busy=%b want 1 0f 0 0000 1",
                         c, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready, bus.busy);
            else n_pass++;
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0000)
            $display("FAIL bp_handshake_ready: got %b want 0000", bus.req_ready);
        else n_pass++;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.busy, bus.req_ready} !== {1'b0, 1'b0, 4'b0010})
            $display("FAIL bp_idle_grant: got v=%b busy=%b rdy=%b want 0 0 0010",
                     bus.rsp_valid, bus.busy, bus.req_ready);
        else n_pass++;
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_a     = {8'h99, 8'h0C, 8'h00, 8'h40};
        bus.req_b     = {8'h99, 8'h30, 8'h00, 8'h02};
        bus.req_valid = 4'b0001;
        tick();
        n_checks++;
        if (bus.busy !== 1'b1)
            $display("FAIL rmid_exec_busy: got %b want 1", bus.busy);
        else n_pass++;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1100;
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0000)
            $display("FAIL rmid_ready_in_reset: got %b want 0000", bus.req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.busy} !== 36'd0)
            $display("FAIL rmid_cleared: got rdy=%b a=%h b=%h v=%b s=%h id=%0d busy=%b want all zero",
                     bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.busy);
        else n_pass++;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0100)
            $display("FAIL rmid_regrant: got %b want 0100", bus.req_ready);
        else n_pass++;
        tick();
        bus.req_valid = '0;
        tick();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id} !== {1'b1, 8'h3C, 3'd2})
            $display("FAIL rmid_resp: got v=%b sum=%h id=%0d want 1 3c 2",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
        else n_pass++;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_withdrawn();
        do_reset();
        bus.req_a     = {8'h00, 8'h00, 8'h07, 8'h01};
        bus.req_b     = {8'h00, 8'h00, 8'h07, 8'h01};
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        bus.req_valid = 4'b0010;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0000)
            $display("FAIL wd_ready_in_resp: got %b want 0000", bus.req_ready);
        else n_pass++;
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({bus.req_ready, bus.rsp_valid, bus.busy} !== {4'b0000, 1'b0, 1'b0})
                $display("FAIL wd_no_grant%0d: got rdy=%b v=%b busy=%b want 0000 0 0",
                         c, bus.req_ready, bus.rsp_valid, bus.busy);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_withdrawn();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Round-robin scheduler that shares one external WIDTH-bit combinational adder among NREQ requesters in the MCU datapath.
- Each requester presents an operand pair with a valid/ready handshake.
- The block registers the winning operands onto the adder inputs, captures the sum, and returns it with the requester ID on a valid/ready response channel.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result bit width; must match the shared adder instance.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 3, width of the requester ID field; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot grant/accept strobe.
- req_a  input  NREQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  flattened operand B; same packing as req_a.
- add_a  output  WIDTH  registered operand A to the shared adder.
- add_b  output  WIDTH  registered operand B to the shared adder.
- add_y  input  WIDTH  sum returned by the shared adder (combinational from add_a/add_b).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  registered sum, truncated to WIDTH (carry discarded, same as adder).
- rsp_id  output  IDW  index of the requester that owns rsp_sum.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Reset (rst_n low at a rising edge):
- State goes to IDLE.
- Outputs: req_ready=0, add_a=0, add_b=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.
- last_grant=NREQ-1, so requester 0 has top priority after reset.
- Reset asserted in any state aborts the in-flight operation; the result is lost and no response is issued.

FSM states: IDLE, EXEC, RESP.

IDLE:
- req_ready is combinational: a one-hot of the round-robin winner among the req_valid bits.
- Search order is last_grant+1, last_grant+2, … modulo NREQ.
- req_ready=0 when no req_valid bit is set.
- Accept: on the edge where req_valid[i]&req_ready[i]=1:
  - add_a<=req_a[i], add_b<=req_b[i].
  - rsp_id<=i, last_grant<=i.
  - State goes to EXEC.

EXEC (exactly one cycle):
- req_ready=0.
- rsp_sum<=add_y, rsp_valid<=1; state goes to RESP.

RESP:
- rsp_valid held at 1; rsp_sum and rsp_id stable; req_ready=0.
- On rsp_ready=1: rsp_valid<=0, state goes to IDLE.
- The next grant can occur in the cycle after IDLE is re-entered. There is no grant in the same cycle as the response handshake.

Latency and throughput:
- Accept at edge T; add_a/add_b valid after T; rsp_valid=1 after edge T+1.
- Minimum issue interval is 3 cycles (rsp_ready tied high).

Handshake rules:
- A requester keeps req_valid and its operands stable until it sees req_ready.
- Deasserting req_valid before the grant is allowed. The arbiter re-evaluates every IDLE cycle; no stale grant is issued.
- req_ready is never asserted outside IDLE or during reset.

Boundary conditions:
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…; no requester waits more than NREQ-1 grants.
- Single requester: it wins every time regardless of last_grant.
- Wrap-around: sum overflow is truncated, e.g. 8'hFF+8'h01 gives rsp_sum=8'h00.
- add_a/add_b hold their last operands after completion; they are not cleared.
- Unused ID codes (>= NREQ) are never driven on rsp_id.

Test Plan:
- Reset, then req_valid=4'b0001 with a0=8'h12, b0=8'h34 → req_ready=4'b0001 in the same cycle; rsp_valid=1 two edges later with rsp_sum=8'h46, rsp_id=0; busy=1 during EXEC/RESP.
- All four requesters valid continuously with rsp_ready=1 → grant sequence 0,1,2,3,0 at 3-cycle spacing; each rsp_sum equals that requester's a+b.
- Overflow: a=8'hFF, b=8'h01 → rsp_sum=8'h00. Also a=8'h80, b=8'h80 → rsp_sum=8'h00.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_sum and rsp_id stable; req_ready=0 throughout despite pending requests; grant only after the rsp_ready handshake and a return to IDLE.
- Reset mid-operation: assert rst_n=0 in EXEC → next cycle has all outputs at reset values and no response. After release with req_valid=4'b1100, requester 2 wins (priority restarts at 0, so 2 is the first set bit).
- Withdrawn request: req_valid[1] pulses for one cycle while in RESP and then drops → no grant to requester 1 and no spurious rsp_valid.
